// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the PYGMY-V32I single-port memory arbiter:
//   - arb_state_e           : 3-bit arbiter FSM state encoding
//   - MAX_LS_STREAK_DEFAULT : default bound on consecutive load/store grants
//                             while instruction fetch is also waiting
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_REQ_IF  = 3'd1,
        ARB_REQ_LS  = 3'd2,
        ARB_WAIT_IF = 3'd3,
        ARB_WAIT_LS = 3'd4
    } arb_state_e;

    localparam int unsigned MAX_LS_STREAK_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// One transaction is in flight at a time: select a requester in IDLE, present
// the request until the memory grants it, then wait for the response and route
// it back to the requester that issued it. LS has priority, but after
// MAX_LS_STREAK consecutive LS grants with IF waiting, IF is served once.
//
// Ports:
//   i_CLK, i_RSTn                  clock, synchronous active-low reset
//   i_IF_REQ/i_IF_ADDR             fetch request and address
//   o_IF_GNT/o_IF_RVALID/o_IF_RDATA fetch accept, response valid, response data
//   i_LS_REQ/WE/BE/ADDR/WDATA      data request and attributes
//   o_LS_GNT/o_LS_RVALID/o_LS_RDATA data accept, response (or write ack), data
//   o_MEM_REQ/WE/BE/ADDR/WDATA     memory bus request and latched attributes
//   i_MEM_GNT/RVALID/RDATA         memory accept, response valid, response data
//   o_STALL                        core stall while a data access is pending
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEFAULT
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,

    input  logic        i_IF_REQ,
    input  logic [31:0] i_IF_ADDR,
    output logic        o_IF_GNT,
    output logic        o_IF_RVALID,
    output logic [31:0] o_IF_RDATA,

    input  logic        i_LS_REQ,
    input  logic        i_LS_WE,
    input  logic [3:0]  i_LS_BE,
    input  logic [31:0] i_LS_ADDR,
    input  logic [31:0] i_LS_WDATA,
    output logic        o_LS_GNT,
    output logic        o_LS_RVALID,
    output logic [31:0] o_LS_RDATA,

    output logic        o_MEM_REQ,
    output logic        o_MEM_WE,
    output logic [3:0]  o_MEM_BE,
    output logic [31:0] o_MEM_ADDR,
    output logic [31:0] o_MEM_WDATA,
    input  logic        i_MEM_GNT,
    input  logic        i_MEM_RVALID,
    input  logic [31:0] i_MEM_RDATA,

    output logic        o_STALL
);

    // Wide enough to hold MAX_LS_STREAK itself; the counter saturates there.
    localparam int unsigned StreakW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_LS_STREAK);

    arb_state_e          state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                mem_we_q, mem_we_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                sel_ls;
    logic                sel_if;
    logic                if_rvalid;
    logic                ls_rvalid;

    // -------------------------------------------------------------------------
    // Arbitration, attribute capture and next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sel_ls      = 1'b0;
        sel_if      = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // LS wins unless IF has already waited out a full LS streak.
                if (i_LS_REQ && !(i_IF_REQ && (streak_q == StreakMax))) begin
                    sel_ls = 1'b1;
                end else if (i_IF_REQ) begin
                    sel_if = 1'b1;
                end

                if (sel_ls) begin
                    state_d     = ARB_REQ_LS;
                    mem_we_d    = i_LS_WE;
                    mem_be_d    = i_LS_BE;
                    mem_addr_d  = i_LS_ADDR;
                    mem_wdata_d = i_LS_WDATA;
                    // Only LS grants that IF had to sit through count.
                    if (!i_IF_REQ) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (sel_if) begin
                    state_d     = ARB_REQ_IF;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = i_IF_ADDR;
                    mem_wdata_d = 32'h0;
                    streak_d    = '0;
                end
            end

            ARB_REQ_IF: begin
                if (i_MEM_GNT) begin
                    state_d = ARB_WAIT_IF;
                end
            end

            ARB_REQ_LS: begin
                if (i_MEM_GNT) begin
                    state_d = ARB_WAIT_LS;
                end
            end

            ARB_WAIT_IF: begin
                if (i_MEM_RVALID) begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_WAIT_LS: begin
                if (i_MEM_RVALID) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and attribute registers (synchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Handshake outputs are qualified with i_RSTn so nothing is forwarded during
    // the reset cycle itself, before the state register has returned to IDLE.
    // GNT outside REQ_* and RVALID outside WAIT_* are dropped by construction.
    always_comb begin
        if_rvalid   = i_RSTn && (state_q == ARB_WAIT_IF) && i_MEM_RVALID;
        ls_rvalid   = i_RSTn && (state_q == ARB_WAIT_LS) && i_MEM_RVALID;

        o_MEM_REQ   = (state_q == ARB_REQ_IF) || (state_q == ARB_REQ_LS);
        o_MEM_WE    = mem_we_q;
        o_MEM_BE    = mem_be_q;
        o_MEM_ADDR  = mem_addr_q;
        o_MEM_WDATA = mem_wdata_q;

        o_IF_GNT    = i_RSTn && (state_q == ARB_REQ_IF) && i_MEM_GNT;
        o_LS_GNT    = i_RSTn && (state_q == ARB_REQ_LS) && i_MEM_GNT;
        o_IF_RVALID = if_rvalid;
        o_LS_RVALID = ls_rvalid;
        o_IF_RDATA  = if_rvalid ? i_MEM_RDATA : 32'h0;
        o_LS_RDATA  = ls_rvalid ? i_MEM_RDATA : 32'h0;

        // Stall from the moment LS asks until its response arrives; the
        // response cycle itself releases the pipeline.
        o_STALL     = i_RSTn
                      && (i_LS_REQ || (state_q == ARB_REQ_LS) || (state_q == ARB_WAIT_LS))
                      && !ls_rvalid;
    end

endmodule
